// File: rtl/pc_pkg.sv
// pc_pkg -- shared constants and types for the fetch PC controller.
//   RESET_PC   : fetch address loaded by reset
//   PC_STEP    : sequential fetch increment in bytes
//   pc_state_e : controller state (BOOT / RUN / PEND)
package pc_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_target_sel.sv
// pc_target_sel -- combinational redirect priority select.
//   jr_take/jr_target : register-indirect redirect (highest priority)
//   j_take/j_target   : j/jal redirect
//   br_take/br_target : taken branch (lowest priority)
//   target            : winning target (0 when nothing is taken)
//   any_take          : at least one redirect requested
module pc_target_sel (
  input  logic        jr_take,
  input  logic [31:0] jr_target,
  input  logic        j_take,
  input  logic [31:0] j_target,
  input  logic        br_take,
  input  logic [31:0] br_target,
  output logic [31:0] target,
  output logic        any_take
);

  always_comb begin
    target = '0;
    if (jr_take)     target = jr_target;
    else if (j_take) target = j_target;
    else if (br_take) target = br_target;
  end

  assign any_take = jr_take | j_take | br_take;

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl -- fetch PC register with redirect selection and stall buffering.
//   clk, reset      : clock, synchronous active-high reset
//   stall           : freeze; pc holds while high
//   br/j/jr_take    : redirect requests (priority jr > j > br)
//   br/j/jr_target  : matching redirect targets
//   pc, pc4         : current fetch address and pc+4 (combinational)
//   fetch_valid     : pc is a real fetch this cycle (not BOOT)
//   redir_pend      : a redirect is buffered behind a stall
//   fetch_err       : misaligned fetch (only with PC_ALIGN_CHK_EN)
// Macro PC_ALIGN_CHK_EN: defined -> targets load unmodified and misaligned
// fetches are flagged; undefined -> target bits [1:0] are cleared and
// fetch_err is tied low.
module pc_ctrl
  import pc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        j_take,
  input  logic [31:0] j_target,
  input  logic        jr_take,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        fetch_valid,
  output logic        redir_pend,
  output logic        fetch_err
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] sel_target;
  logic [31:0] load_tgt;
  logic        any_take;

  pc_target_sel u_sel (
    .jr_take   (jr_take),
    .jr_target (jr_target),
    .j_take    (j_take),
    .j_target  (j_target),
    .br_take   (br_take),
    .br_target (br_target),
    .target    (sel_target),
    .any_take  (any_take)
  );

`ifdef PC_ALIGN_CHK_EN
  assign load_tgt  = sel_target;
  assign fetch_err = (pc_q[1:0] != 2'b00) && fetch_valid;
`else
  // Word-align the target here so both the direct load and the pending
  // capture see the same forced value.
  assign load_tgt  = sel_target & ~32'h3;
  assign fetch_err = 1'b0;
`endif

  assign pc  = pc_q;
  assign pc4 = pc_q + PC_STEP;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (stall && any_take) state_d = ST_PEND;
      ST_PEND: if (!stall) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // PC / pending target update. In PEND new takes are ignored so the first
  // captured redirect wins.
  always_comb begin
    pc_d   = pc_q;
    pend_d = pend_q;
    case (state_q)
      ST_RUN: begin
        if (!stall)        pc_d   = any_take ? load_tgt : pc4;
        else if (any_take) pend_d = load_tgt;
      end
      ST_PEND: begin
        if (!stall) begin
          pc_d   = pend_q;
          pend_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    fetch_valid = (state_q != ST_BOOT);
    redir_pend  = (state_q == ST_PEND);
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl -- directed plus randomized check of pc_ctrl against a
// behavioural model of the fetch-address rules.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic        br_take, j_take, jr_take;
  logic [31:0] br_target, j_target, jr_target;
  logic [31:0] pc, pc4;
  logic        fetch_valid, redir_pend, fetch_err;

  int total = 0;
  int bad   = 0;

  // behavioural model
  logic [31:0] m_pc, m_ptgt;
  bit          m_boot, m_pend;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_take(br_take), .br_target(br_target),
    .j_take(j_take), .j_target(j_target),
    .jr_take(jr_take), .jr_target(jr_target),
    .pc(pc), .pc4(pc4), .fetch_valid(fetch_valid),
    .redir_pend(redir_pend), .fetch_err(fetch_err)
  );

  function automatic logic [31:0] fix(input logic [31:0] t);
`ifdef PC_ALIGN_CHK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] t;
    bit          tk;
    tk = jr_take | j_take | br_take;
    t  = jr_take ? jr_target : (j_take ? j_target : br_target);
    if (reset) begin
      m_pc = 32'h3000; m_boot = 1; m_pend = 0; m_ptgt = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_pend) begin
      if (!stall) begin m_pc = m_ptgt; m_pend = 0; m_ptgt = 0; end
    end else if (!stall) begin
      m_pc = tk ? fix(t) : m_pc + 32'd4;
    end else if (tk) begin
      m_pend = 1; m_ptgt = fix(t);
    end
  endtask

  // one clock: model advances on the edge, outputs compared half a cycle later
  task automatic tick();
    logic exp_err;
    @(posedge clk);
    model_step();
    @(negedge clk);
`ifdef PC_ALIGN_CHK_EN
    exp_err = (m_pc[1:0] != 2'b00) && !m_boot;
`else
    exp_err = 1'b0;
`endif
    chk("pc",          pc,          m_pc);
    chk("pc4",         pc4,         m_pc + 32'd4);
    chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, !m_boot});
    chk("redir_pend",  {31'd0, redir_pend},  {31'd0, m_pend});
    chk("fetch_err",   {31'd0, fetch_err},   {31'd0, exp_err});
  endtask

  task automatic idle();
    stall = 0; br_take = 0; j_take = 0; jr_take = 0;
    br_target = 0; j_target = 0; jr_target = 0;
  endtask

  initial begin
    m_pc = 0; m_ptgt = 0; m_boot = 1; m_pend = 0;
    reset = 1; idle();
    tick(); tick();

    // boot sequence
    reset = 0;
    chk("boot_pc0", pc, 32'h3000); chk("boot_fv0", {31'd0, fetch_valid}, 32'd0);
    tick(); chk("boot_pc1", pc, 32'h3000); chk("boot_fv1", {31'd0, fetch_valid}, 32'd1);
    tick(); chk("seq_3004", pc, 32'h3004);
    tick(); chk("seq_3008", pc, 32'h3008);
    tick(); tick(); chk("seq_3010", pc, 32'h3010);

    // branch
    br_take = 1; br_target = 32'h3100;
    tick(); chk("br_pc", pc, 32'h3100); chk("br_pc4", pc4, 32'h3104);

    // priority
    jr_take = 1; jr_target = 32'h4000; j_take = 1; j_target = 32'h5000;
    br_take = 1; br_target = 32'h6000;
    tick(); chk("prio_jr", pc, 32'h4000);

    // redirect buffered behind a 3-cycle stall; later br is dropped
    idle(); stall = 1; j_take = 1; j_target = 32'h3200;
    tick(); chk("pend_pc0", pc, 32'h4000); chk("pend_f0", {31'd0, redir_pend}, 32'd1);
    j_take = 0; br_take = 1; br_target = 32'h3300;
    tick(); chk("pend_pc1", pc, 32'h4000); chk("pend_f1", {31'd0, redir_pend}, 32'd1);
    tick(); chk("pend_pc2", pc, 32'h4000); chk("pend_f2", {31'd0, redir_pend}, 32'd1);
    idle();
    tick(); chk("pend_rel", pc, 32'h3200); chk("pend_clr", {31'd0, redir_pend}, 32'd0);

    // reset during PEND discards the buffered target
    stall = 1; j_take = 1; j_target = 32'h3400;
    tick(); chk("rstp_pend", {31'd0, redir_pend}, 32'd1);
    reset = 1;
    tick(); chk("rstp_pc", pc, 32'h3000); chk("rstp_flag", {31'd0, redir_pend}, 32'd0);
    reset = 0; idle();
    tick(); chk("rstp_boot", pc, 32'h3000);
    tick(); chk("rstp_seq", pc, 32'h3004);

    // misaligned target
    jr_take = 1; jr_target = 32'h3006;
    tick();
`ifdef PC_ALIGN_CHK_EN
    chk("mis_pc", pc, 32'h3006); chk("mis_err", {31'd0, fetch_err}, 32'd1);
`else
    chk("mis_pc", pc, 32'h3004); chk("mis_err", {31'd0, fetch_err}, 32'd0);
`endif

    // wrap
    jr_target = 32'hFFFF_FFFC;
    tick(); chk("wrap_top", pc, 32'hFFFF_FFFC); chk("wrap_pc4", pc4, 32'h0);
    idle();
    tick(); chk("wrap_pc", pc, 32'h0);

    // randomized
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      stall     = ($urandom_range(0, 9) < 4);
      br_take   = ($urandom_range(0, 6) == 0);
      j_take    = ($urandom_range(0, 6) == 0);
      jr_take   = ($urandom_range(0, 6) == 0);
      br_target = $urandom;
      j_target  = $urandom;
      jr_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
